// File: rtl/ascon_word_packer.sv
// ascon_word_packer
//   Width adapter between the 32-bit OBI register block and the CCW-bit ASCON
//   datapath.
//   Input path : packs 32-bit words (first word at the MSB) into CCW-bit
//                blocks and offers them to the controller.
//   Output path: buffers CCW-bit results in a circular FIFO of 32-bit words
//                and presents them one word at a time to the register block.
//   The two paths share no state and may both transfer in the same cycle.
//
// Ports
//   clk_i, rst_i (sync, active-high), flush_i (sync clear, same as reset)
//   in_data_i/in_valid_i/in_last_i/in_ready_o       : word input
//   blk_data_o/blk_words_o/blk_last_o/blk_valid_o/blk_ready_i : block output
//   res_data_i/res_words_i/res_valid_i/res_ready_o  : result input
//   out_data_o/out_valid_o/out_ready_i              : word output
//   level_o                                         : words held in the FIFO
module ascon_word_packer #(
  parameter int unsigned CCW   = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [31:0]                      in_data_i,
  input  logic                             in_valid_i,
  input  logic                             in_last_i,
  output logic                             in_ready_o,
  output logic [CCW-1:0]                   blk_data_o,
  output logic [$clog2(CCW/32+1)-1:0]      blk_words_o,
  output logic                             blk_last_o,
  output logic                             blk_valid_o,
  input  logic                             blk_ready_i,
  input  logic [CCW-1:0]                   res_data_i,
  input  logic [$clog2(CCW/32+1)-1:0]      res_words_i,
  input  logic                             res_valid_i,
  output logic                             res_ready_o,
  output logic [31:0]                      out_data_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]       level_o
);

  localparam int unsigned W  = CCW / 32;
  localparam int unsigned WW = $clog2(W + 1);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic clr;
  assign clr = rst_i | flush_i;

  // ---------------------------------------------------------------------------
  // Packer
  // ---------------------------------------------------------------------------
  // S_IDLE holds in_ready_o low for the first cycle after reset/flush.
  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_SEND
  } pk_state_e;

  pk_state_e      state_q, state_d;
  logic [CCW-1:0] data_q;
  logic [WW-1:0]  idx_q;
  logic [WW-1:0]  words_q;
  logic           last_q;
  logic [CCW-1:0] word_at_msb;
  logic           accept;

  assign word_at_msb = CCW'(in_data_i) << (CCW - 32);
  assign accept      = in_ready_o & in_valid_i;

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    blk_valid_o = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FILL;
      S_FILL: begin
        in_ready_o = 1'b1;
        if (in_valid_i && (in_last_i || idx_q == WW'(W - 1))) state_d = S_SEND;
      end
      S_SEND: begin
        blk_valid_o = 1'b1;
        if (blk_ready_i) state_d = S_FILL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign blk_data_o  = blk_valid_o ? data_q  : '0;
  assign blk_words_o = blk_valid_o ? words_q : '0;
  assign blk_last_o  = blk_valid_o & last_q;

  always_ff @(posedge clk_i) begin
    if (clr) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      words_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // The buffer is zeroed between blocks, so OR-ing the shifted word in
        // places it and leaves the unused low words at zero.
        data_q  <= data_q | (word_at_msb >> (32 * idx_q));
        idx_q   <= idx_q + 1'b1;
        words_q <= idx_q + 1'b1;
        last_q  <= in_last_i;
      end
      if (blk_valid_o && blk_ready_i) begin
        data_q  <= '0;
        idx_q   <= '0;
        words_q <= '0;
        last_q  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          live_q;
  logic [WW-1:0] push_cnt;
  logic          push, pop;

  // Illegal word counts are clamped to a full block.
  always_comb begin
    push_cnt = res_words_i;
    if (res_words_i == '0 || res_words_i > WW'(W)) push_cnt = WW'(W);
  end

  assign res_ready_o = live_q && ((DEPTH - 32'(level_q)) >= W);
  assign out_valid_o = (level_q != '0);
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o     = level_q;
  assign push        = res_valid_i & res_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      live_q   <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (push) wr_ptr_q <= PW'((32'(wr_ptr_q) + 32'(push_cnt)) % DEPTH);
      if (pop)  rd_ptr_q <= PW'((32'(rd_ptr_q) + 1) % DEPTH);
      level_q <= level_q + (push ? LW'(push_cnt) : LW'(0)) - (pop ? LW'(1) : LW'(0));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < W; i++) begin
      if (push && i < 32'(push_cnt))
        mem_q[PW'((32'(wr_ptr_q) + i) % DEPTH)] <= res_data_i[CCW-1-32*i -: 32];
    end
  end

  a_res_words_legal : assert property (@(posedge clk_i) disable iff (clr)
    (res_valid_i && res_ready_o) |-> (res_words_i != '0 && res_words_i <= WW'(W)));

endmodule

// File: tb/tb_ascon_word_packer.sv
// Directed self-checking bench for ascon_word_packer (CCW=64, DEPTH=4).
module tb_ascon_word_packer;

  localparam int unsigned CCW   = 64;
  localparam int unsigned DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_i, flush_i;
  logic [31:0]   in_data_i;
  logic          in_valid_i, in_last_i, in_ready_o;
  logic [63:0]   blk_data_o;
  logic [1:0]    blk_words_o;
  logic          blk_last_o, blk_valid_o, blk_ready_i;
  logic [63:0]   res_data_i;
  logic [1:0]    res_words_i;
  logic          res_valid_i, res_ready_o;
  logic [31:0]   out_data_o;
  logic          out_valid_o, out_ready_i;
  logic [2:0]    level_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  ascon_word_packer #(.CCW(CCW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_last_i(in_last_i),
    .in_ready_o(in_ready_o),
    .blk_data_o(blk_data_o), .blk_words_o(blk_words_o), .blk_last_o(blk_last_o),
    .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i),
    .res_data_i(res_data_i), .res_words_i(res_words_i), .res_valid_i(res_valid_i),
    .res_ready_o(res_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .level_o(level_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] model_q[$];
  logic [31:0] pop_exp[4];
  int          mlevel, max_level;
  logic        exp_ready, exp_pop;
  logic [31:0] w0, w1;

  initial begin
    rst_i = 1'b1; flush_i = 1'b0;
    in_data_i = '0; in_valid_i = 1'b0; in_last_i = 1'b0; blk_ready_i = 1'b0;
    res_data_i = '0; res_words_i = 2'd2; res_valid_i = 1'b0; out_ready_i = 1'b0;
    tick(); tick();
    check("rst_in_ready", 64'(in_ready_o), 64'd0);
    check("rst_blk_valid", 64'(blk_valid_o), 64'd0);
    check("rst_res_ready", 64'(res_ready_o), 64'd0);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_level", 64'(level_o), 64'd0);
    rst_i = 1'b0;
    check("rel_in_ready_low", 64'(in_ready_o), 64'd0);
    tick();
    check("rel_in_ready_high", 64'(in_ready_o), 64'd1);

    // Full two-word block
    in_valid_i = 1'b1; in_data_i = 32'hA1; in_last_i = 1'b0;
    tick();
    check("w0_no_blk", 64'(blk_valid_o), 64'd0);
    in_data_i = 32'hB2;
    tick();
    in_valid_i = 1'b0;
    check("b0_valid", 64'(blk_valid_o), 64'd1);
    check("b0_data", blk_data_o, 64'h000000A1_000000B2);
    check("b0_words", 64'(blk_words_o), 64'd2);
    check("b0_last", 64'(blk_last_o), 64'd0);
    check("b0_in_ready", 64'(in_ready_o), 64'd0);
    blk_ready_i = 1'b1;
    tick();
    blk_ready_i = 1'b0;
    check("b0_done_valid", 64'(blk_valid_o), 64'd0);
    check("b0_done_in_ready", 64'(in_ready_o), 64'd1);

    // Short last block, held under backpressure
    in_valid_i = 1'b1; in_data_i = 32'hC3; in_last_i = 1'b1;
    tick();
    in_valid_i = 1'b0; in_last_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("b1_valid", 64'(blk_valid_o), 64'd1);
      check("b1_data", blk_data_o, 64'h000000C3_00000000);
      check("b1_words", 64'(blk_words_o), 64'd1);
      check("b1_last", 64'(blk_last_o), 64'd1);
      check("b1_in_ready", 64'(in_ready_o), 64'd0);
      tick();
    end
    blk_ready_i = 1'b1;
    tick();
    blk_ready_i = 1'b0;
    check("b1_done_valid", 64'(blk_valid_o), 64'd0);
    check("b1_done_in_ready", 64'(in_ready_o), 64'd1);

    // FIFO fill to full, attempted overflow, drain
    check("f_ready_empty", 64'(res_ready_o), 64'd1);
    res_data_i = 64'h11111111_22222222; res_words_i = 2'd2; res_valid_i = 1'b1;
    tick();
    check("f_level2", 64'(level_o), 64'd2);
    check("f_out_valid", 64'(out_valid_o), 64'd1);
    tick();
    check("f_level4", 64'(level_o), 64'd4);
    check("f_ready_full", 64'(res_ready_o), 64'd0);
    res_data_i = 64'hDEADBEEF_DEADBEEF;
    tick();
    res_valid_i = 1'b0;
    check("f_full_hold", 64'(level_o), 64'd4);
    pop_exp[0] = 32'h11111111; pop_exp[1] = 32'h22222222;
    pop_exp[2] = 32'h11111111; pop_exp[3] = 32'h22222222;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("f_pop_data", 64'(out_data_o), 64'(pop_exp[i]));
      tick();
    end
    check("f_empty_level", 64'(level_o), 64'd0);
    check("f_empty_valid", 64'(out_valid_o), 64'd0);
    tick();
    check("f_empty_pop_ignored", 64'(level_o), 64'd0);
    out_ready_i = 1'b0;

    // Single-word result: only the MSB word is stored
    res_data_i = 64'h33333333_44444444; res_words_i = 2'd1; res_valid_i = 1'b1;
    tick();
    res_valid_i = 1'b0;
    check("one_level", 64'(level_o), 64'd1);
    check("one_data", 64'(out_data_o), 64'h33333333);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("one_drained", 64'(level_o), 64'd0);

    // Sustained push of 2 words while popping 1 per cycle, against a queue model
    model_q.delete();
    mlevel = 0; max_level = 0;
    out_ready_i = 1'b1; res_words_i = 2'd2; res_valid_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w0 = 32'hA0000000 + 32'(2 * i);
      w1 = 32'hA0000000 + 32'(2 * i + 1);
      res_data_i = {w0, w1};
      exp_ready = (DEPTH - mlevel) >= 2;
      exp_pop   = mlevel != 0;
      check("s_res_ready", 64'(res_ready_o), 64'(exp_ready));
      if (exp_pop) check("s_out_data", 64'(out_data_o), 64'(model_q[0]));
      tick();
      if (exp_pop) void'(model_q.pop_front());
      if (exp_ready) begin model_q.push_back(w0); model_q.push_back(w1); end
      mlevel = model_q.size();
      if (32'(level_o) > 32'(max_level)) max_level = 32'(level_o);
      check("s_level", 64'(level_o), 64'(mlevel));
    end
    res_valid_i = 1'b0;
    for (int i = 0; i < 8 && model_q.size() != 0; i++) begin
      check("s_drain_data", 64'(out_data_o), 64'(model_q[0]));
      tick();
      void'(model_q.pop_front());
    end
    check("s_drain_level", 64'(level_o), 64'd0);
    check("s_max_level_le4", 64'(max_level <= 4), 64'd1);
    out_ready_i = 1'b0;

    // Flush with a half-filled block and 3 words in the FIFO
    in_valid_i = 1'b1; in_data_i = 32'hD4; in_last_i = 1'b0;
    res_data_i = 64'h55555555_66666666; res_words_i = 2'd2; res_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick();
    res_valid_i = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("fl_pre_level3", 64'(level_o), 64'd3);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("fl_level", 64'(level_o), 64'd0);
    check("fl_out_valid", 64'(out_valid_o), 64'd0);
    check("fl_blk_valid", 64'(blk_valid_o), 64'd0);
    check("fl_in_ready_low", 64'(in_ready_o), 64'd0);
    tick();
    check("fl_in_ready_high", 64'(in_ready_o), 64'd1);
    in_valid_i = 1'b1; in_data_i = 32'hE5; in_last_i = 1'b1;
    tick();
    in_valid_i = 1'b0; in_last_i = 1'b0;
    check("fl_blk_data", blk_data_o, 64'h000000E5_00000000);
    check("fl_blk_words", 64'(blk_words_o), 64'd1);
    blk_ready_i = 1'b1;
    tick();
    blk_ready_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
